execute_stage: RTL and testbench

- Consumer end of the ID/EX pipeline bundle. Takes the registered decode outputs and performs operand forwarding, immediate reconstruction and the ALU operation.
- Resolves conditional branches and raises the redirect/flush towards fetch and decode.
- Captures results into the EX/MEM pipeline register for the memory stage.
- Also detects load-use hazards and raises a stall towards fetch/decode.

---
 rtl/execute_stage_if.sv | 53 +++++
 rtl/execute_stage.sv | 148 ++++++++++++++
 tb/tb_execute_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// ID/EX consumer bundle for the execute stage: decode controls, operands,
// forwarding sources, branch/stall outputs towards fetch/decode and the EX/MEM register.
interface execute_stage_if #(
    parameter int XLEN = 32,
    parameter int RNUM = 5
);
    logic [2:0]      ALU_CONTROL;
    logic [1:0]      ALU_SRC2;
    logic            BRN_COND;
    logic            MEM_WE;
    logic            DE_WE;
    logic            MEM_REG;
    logic [XLEN-1:0] D1;
    logic [XLEN-1:0] D2;
    logic [24:0]     Imm;
    logic [XLEN-1:0] PC_EX;
    logic [RNUM-1:0] RS1_EX;
    logic [RNUM-1:0] RS2_EX;
    logic [RNUM-1:0] RS1_D;
    logic [RNUM-1:0] RS2_D;
    logic [XLEN-1:0] FWD_M_D;
    logic [RNUM-1:0] FWD_M_A;
    logic            FWD_M_WE;
    logic [XLEN-1:0] WB_D;
    logic [RNUM-1:0] WB_A;
    logic            WB_WE;
    logic            BRN_TAKEN;
    logic [XLEN-1:0] BRN_TARGET;
    logic            FLUSH;
    logic            STALL;
    logic [XLEN-1:0] ALU_OUT_M;
    logic [XLEN-1:0] WDATA_M;
    logic [RNUM-1:0] RD_M;
    logic            MEM_WE_M;
    logic            DE_WE_M;
    logic            MEM_REG_M;

    modport master (
        output ALU_CONTROL, ALU_SRC2, BRN_COND, MEM_WE, DE_WE, MEM_REG,
               D1, D2, Imm, PC_EX, RS1_EX, RS2_EX, RS1_D, RS2_D,
               FWD_M_D, FWD_M_A, FWD_M_WE, WB_D, WB_A, WB_WE,
        input  BRN_TAKEN, BRN_TARGET, FLUSH, STALL,
               ALU_OUT_M, WDATA_M, RD_M, MEM_WE_M, DE_WE_M, MEM_REG_M
    );

    modport slave (
        input  ALU_CONTROL, ALU_SRC2, BRN_COND, MEM_WE, DE_WE, MEM_REG,
               D1, D2, Imm, PC_EX, RS1_EX, RS2_EX, RS1_D, RS2_D,
               FWD_M_D, FWD_M_A, FWD_M_WE, WB_D, WB_A, WB_WE,
        output BRN_TAKEN, BRN_TARGET, FLUSH, STALL,
               ALU_OUT_M, WDATA_M, RD_M, MEM_WE_M, DE_WE_M, MEM_REG_M
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, immediate rebuild, ALU, branch resolution,
// load-use stall detection and the EX/MEM pipeline register.
module execute_stage #(
    parameter int XLEN = 32,
    parameter int RNUM = 5
) (
    input logic          clk,
    input logic          rst,
    execute_stage_if.slave bus
);

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RNUM-1:0] rs,
        input logic [XLEN-1:0] rf_data,
        input logic            m_we,
        input logic [RNUM-1:0] m_a,
        input logic [XLEN-1:0] m_d,
        input logic            wb_we,
        input logic [RNUM-1:0] wb_a,
        input logic [XLEN-1:0] wb_d
    );
        logic [XLEN-1:0] res;
        res = rf_data;
        if (rs != '0) begin
            if (m_we && (m_a == rs))
                res = m_d;
            else if (wb_we && (wb_a == rs))
                res = wb_d;
        end
        return res;
    endfunction

    function automatic logic [XLEN-1:0] alu(
        input logic [2:0]             op,
        input logic signed [XLEN-1:0] a,
        input logic signed [XLEN-1:0] b
    );
        logic [XLEN-1:0] res;
        case (op)
            3'b000:  res = a + b;
            3'b001:  res = a - b;
            3'b010:  res = a & b;
            3'b011:  res = a | b;
            3'b100:  res = a ^ b;
            3'b101:  res = a << b[4:0];
            3'b110:  res = a >> b[4:0];
            default: res = {{(XLEN-1){1'b0}}, (a < b)};
        endcase
        return res;
    endfunction

    function automatic logic br_cmp(
        input logic [2:0]             f3,
        input logic signed [XLEN-1:0] a,
        input logic signed [XLEN-1:0] b
    );
        logic res;
        case (f3)
            3'b000:  res = (a == b);
            3'b001:  res = (a != b);
            3'b100:  res = (a < b);
            3'b101:  res = (a >= b);
            3'b110:  res = ($unsigned(a) < $unsigned(b));
            3'b111:  res = ($unsigned(a) >= $unsigned(b));
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [RNUM-1:0]        w_rd;
    logic [2:0]             w_funct3;
    logic signed [XLEN-1:0] w_imm_i;
    logic signed [XLEN-1:0] w_imm_s;
    logic signed [XLEN-1:0] w_imm_u;
    logic signed [XLEN-1:0] w_imm_b;
    logic signed [XLEN-1:0] w_op_a;
    logic signed [XLEN-1:0] w_fwd_b;
    logic signed [XLEN-1:0] w_op2;
    logic [XLEN-1:0]        w_alu;
    logic                   w_taken;

    // Imm carries instruction bits [31:7], so instr bit n sits at Imm[n-7]
    assign w_rd     = bus.Imm[4:0];
    assign w_funct3 = bus.Imm[7:5];
    assign w_imm_i  = {{(XLEN-12){bus.Imm[24]}}, bus.Imm[24:13]};
    assign w_imm_s  = {{(XLEN-12){bus.Imm[24]}}, bus.Imm[24:18], bus.Imm[4:0]};
    assign w_imm_u  = {bus.Imm[24:5], 12'b0};
    assign w_imm_b  = {{(XLEN-13){bus.Imm[24]}}, bus.Imm[24], bus.Imm[0],
                       bus.Imm[23:18], bus.Imm[4:1], 1'b0};

    assign w_op_a  = fwd_sel(bus.RS1_EX, bus.D1, bus.FWD_M_WE, bus.FWD_M_A, bus.FWD_M_D,
                             bus.WB_WE, bus.WB_A, bus.WB_D);
    assign w_fwd_b = fwd_sel(bus.RS2_EX, bus.D2, bus.FWD_M_WE, bus.FWD_M_A, bus.FWD_M_D,
                             bus.WB_WE, bus.WB_A, bus.WB_D);

    always_comb begin
        w_op2 = w_fwd_b;
        case (bus.ALU_SRC2)
            2'b01:   w_op2 = w_imm_i;
            2'b10:   w_op2 = w_imm_s;
            2'b11:   w_op2 = w_imm_u;
            default: w_op2 = w_fwd_b;
        endcase
    end

    assign w_alu   = alu(bus.ALU_CONTROL, w_op_a, w_op2);
    assign w_taken = bus.BRN_COND & br_cmp(w_funct3, w_op_a, w_fwd_b);

    assign bus.BRN_TAKEN  = w_taken;
    assign bus.FLUSH      = w_taken;
    assign bus.BRN_TARGET = bus.PC_EX + w_imm_b;
    assign bus.STALL      = bus.MEM_REG & bus.DE_WE & (w_rd != '0) &
                            ((w_rd == bus.RS1_D) | (w_rd == bus.RS2_D));

    logic [XLEN-1:0] r_alu_out_p1;
    logic [XLEN-1:0] r_wdata_p1;
    logic [RNUM-1:0] r_rd_p1;
    logic            r_mem_we_p1;
    logic            r_de_we_p1;
    logic            r_mem_reg_p1;

    // EX -> MEM boundary; async clear drops whatever was in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_out_p1 <= '0;
            r_wdata_p1   <= '0;
            r_rd_p1      <= '0;
            r_mem_we_p1  <= 1'b0;
            r_de_we_p1   <= 1'b0;
            r_mem_reg_p1 <= 1'b0;
        end else begin
            r_alu_out_p1 <= w_alu;
            r_wdata_p1   <= w_fwd_b;
            r_rd_p1      <= w_rd;
            r_mem_we_p1  <= bus.MEM_WE;
            r_de_we_p1   <= bus.DE_WE;
            r_mem_reg_p1 <= bus.MEM_REG;
        end
    end

    assign bus.ALU_OUT_M = r_alu_out_p1;
    assign bus.WDATA_M   = r_wdata_p1;
    assign bus.RD_M      = r_rd_p1;
    assign bus.MEM_WE_M  = r_mem_we_p1;
    assign bus.DE_WE_M   = r_de_we_p1;
    assign bus.MEM_REG_M = r_mem_reg_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_execute_stage;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    execute_stage_if #(.XLEN(32), .RNUM(5)) bus ();

    execute_stage #(.XLEN(32), .RNUM(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model: rebuild the 32-bit instruction and decode it directly
    function automatic logic [31:0] m_imm(input logic [1:0] sel, input logic [24:0] imm);
        logic [31:0]        ins;
        logic signed [31:0] t;
        ins = {imm, 7'b0};
        case (sel)
            2'b01: begin t = ins; return 32'(t >>> 20); end
            2'b10: begin t = {ins[31:25], ins[11:7], 20'b0}; return 32'(t >>> 20); end
            2'b11: return ins & 32'hFFFF_F000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_bimm(input logic [24:0] imm);
        logic [31:0]        ins;
        logic signed [31:0] t;
        ins = {imm, 7'b0};
        t = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0};
        return 32'(t >>> 19);
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return rf;
        if (bus.FWD_M_WE && bus.FWD_M_A == rs) return bus.FWD_M_D;
        if (bus.WB_WE && bus.WB_A == rs) return bus.WB_D;
        return rf;
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b & 32'd31);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << sh;
            3'd6: return a >> sh;
            default: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic m_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) < int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [24:0] enc_b(input logic [12:0] off, input logic [2:0] f3);
        logic [24:0] v;
        v = '0;
        v[24] = off[12];
        v[0] = off[11];
        v[23:18] = off[10:5];
        v[4:1] = off[4:1];
        v[7:5] = f3;
        return v;
    endfunction

    task automatic clear_inputs();
        bus.ALU_CONTROL = '0; bus.ALU_SRC2 = '0; bus.BRN_COND = 0; bus.MEM_WE = 0;
        bus.DE_WE = 0; bus.MEM_REG = 0; bus.D1 = '0; bus.D2 = '0; bus.Imm = '0;
        bus.PC_EX = '0; bus.RS1_EX = '0; bus.RS2_EX = '0; bus.RS1_D = '0; bus.RS2_D = '0;
        bus.FWD_M_D = '0; bus.FWD_M_A = '0; bus.FWD_M_WE = 0;
        bus.WB_D = '0; bus.WB_A = '0; bus.WB_WE = 0;
    endtask

    task automatic randomize_inputs();
        bus.ALU_CONTROL = 3'($urandom); bus.ALU_SRC2 = 2'($urandom);
        bus.BRN_COND = 1'($urandom); bus.MEM_WE = 1'($urandom);
        bus.DE_WE = 1'($urandom); bus.MEM_REG = 1'($urandom);
        bus.D1 = $urandom; bus.D2 = $urandom; bus.Imm = 25'($urandom);
        bus.PC_EX = $urandom;
        bus.RS1_EX = 5'($urandom_range(0, 3)); bus.RS2_EX = 5'($urandom_range(0, 3));
        bus.RS1_D = 5'($urandom_range(0, 3)); bus.RS2_D = 5'($urandom_range(0, 3));
        bus.FWD_M_D = $urandom; bus.FWD_M_A = 5'($urandom_range(0, 3));
        bus.FWD_M_WE = 1'($urandom);
        bus.WB_D = $urandom; bus.WB_A = 5'($urandom_range(0, 3)); bus.WB_WE = 1'($urandom);
        if ($urandom_range(0, 3) == 0) bus.Imm[4:0] = bus.RS2_D;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        randomize_inputs();
        tick();
        total++; if (bus.ALU_OUT_M !== 32'd0) begin bad++; $display("FAIL reset_alu got=%h exp=0", bus.ALU_OUT_M); end
        total++; if (bus.WDATA_M !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.WDATA_M); end
        total++; if (bus.RD_M !== 5'd0) begin bad++; $display("FAIL reset_rd got=%h exp=0", bus.RD_M); end
        total++; if ({bus.MEM_WE_M, bus.DE_WE_M, bus.MEM_REG_M} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=000", {bus.MEM_WE_M, bus.DE_WE_M, bus.MEM_REG_M});
        end
        clear_inputs();
        bus.D1 = 32'd5; bus.D2 = 32'd7; bus.DE_WE = 1; bus.Imm = 25'd3;
        rst = 1'b1;
        tick();
        total++; if (bus.ALU_OUT_M !== 32'd12) begin bad++; $display("FAIL first_add got=%0d exp=12", bus.ALU_OUT_M); end
        total++; if (bus.RD_M !== 5'd3) begin bad++; $display("FAIL first_rd got=%0d exp=3", bus.RD_M); end
        total++; if (bus.DE_WE_M !== 1'b1 || bus.MEM_WE_M !== 1'b0) begin
            bad++; $display("FAIL first_ctrl got=%b%b exp=10", bus.DE_WE_M, bus.MEM_WE_M);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        bus.RS1_EX = 5'd4; bus.D1 = 32'd1; bus.ALU_SRC2 = 2'b01; bus.Imm = 25'd1 << 13;
        bus.FWD_M_A = 5'd4; bus.FWD_M_D = 32'd100; bus.FWD_M_WE = 1;
        bus.WB_A = 5'd4; bus.WB_D = 32'd200; bus.WB_WE = 1;
        tick();
        total++; if (bus.ALU_OUT_M !== 32'd101) begin bad++; $display("FAIL fwd_mem_prio got=%0d exp=101", bus.ALU_OUT_M); end
        bus.FWD_M_WE = 0;
        tick();
        total++; if (bus.ALU_OUT_M !== 32'd201) begin bad++; $display("FAIL fwd_wb got=%0d exp=201", bus.ALU_OUT_M); end
        bus.RS1_EX = 5'd0; bus.FWD_M_WE = 1; bus.FWD_M_A = 5'd0; bus.WB_A = 5'd0;
        tick();
        total++; if (bus.ALU_OUT_M !== 32'd2) begin bad++; $display("FAIL fwd_x0 got=%0d exp=2", bus.ALU_OUT_M); end
        bus.ALU_SRC2 = 2'b00; bus.Imm = '0; bus.RS2_EX = 5'd9; bus.D2 = 32'd50;
        bus.FWD_M_A = 5'd9; bus.FWD_M_D = 32'd100; bus.WB_WE = 0;
        tick();
        total++; if (bus.ALU_OUT_M !== 32'd101) begin bad++; $display("FAIL fwd_opb got=%0d exp=101", bus.ALU_OUT_M); end
        total++; if (bus.WDATA_M !== 32'd100) begin bad++; $display("FAIL fwd_wdata got=%0d exp=100", bus.WDATA_M); end
    endtask

    task automatic test_immediates();
        clear_inputs();
        bus.ALU_CONTROL = 3'b001; bus.ALU_SRC2 = 2'b01; bus.Imm = 25'h0FFF << 13; bus.D1 = 32'd10;
        tick();
        total++; if (bus.ALU_OUT_M !== 32'd11) begin bad++; $display("FAIL imm_i_sub got=%0d exp=11", bus.ALU_OUT_M); end
        clear_inputs();
        bus.ALU_SRC2 = 2'b10; bus.MEM_WE = 1; bus.D1 = 32'h1000; bus.D2 = 32'hDEAD;
        bus.Imm = '0; bus.Imm[24:18] = 7'h7F; bus.Imm[4:0] = 5'h1C;
        bus.RS2_EX = 5'd7; bus.WB_A = 5'd7; bus.WB_D = 32'hBEEF; bus.WB_WE = 1;
        tick();
        total++; if (bus.ALU_OUT_M !== 32'h0FFC) begin bad++; $display("FAIL imm_s_addr got=%h exp=00000ffc", bus.ALU_OUT_M); end
        total++; if (bus.WDATA_M !== 32'hBEEF) begin bad++; $display("FAIL store_data got=%h exp=0000beef", bus.WDATA_M); end
        total++; if (bus.MEM_WE_M !== 1'b1) begin bad++; $display("FAIL store_we got=%b exp=1", bus.MEM_WE_M); end
        clear_inputs();
        bus.ALU_SRC2 = 2'b11; bus.Imm = 25'h12345 << 5;
        tick();
        total++; if (bus.ALU_OUT_M !== 32'h1234_5000) begin bad++; $display("FAIL imm_u got=%h exp=12345000", bus.ALU_OUT_M); end
    endtask

    task automatic test_branches();
        clear_inputs();
        bus.PC_EX = 32'h100; bus.BRN_COND = 1; bus.D1 = 32'd9; bus.D2 = 32'd9;
        bus.Imm = enc_b(13'h1FF8, 3'b000);
        #1;
        total++; if (bus.BRN_TAKEN !== 1'b1 || bus.FLUSH !== 1'b1) begin
            bad++; $display("FAIL beq_taken got=%b%b exp=11", bus.BRN_TAKEN, bus.FLUSH);
        end
        total++; if (bus.BRN_TARGET !== 32'hF8) begin bad++; $display("FAIL beq_target got=%h exp=000000f8", bus.BRN_TARGET); end
        bus.BRN_COND = 0;
        #1;
        total++; if (bus.BRN_TAKEN !== 1'b0) begin bad++; $display("FAIL nobranch got=%b exp=0", bus.BRN_TAKEN); end
        bus.BRN_COND = 1; bus.D1 = 32'hFFFF_FFFF; bus.D2 = 32'd1; bus.Imm = enc_b(13'h1FF8, 3'b100);
        #1;
        total++; if (bus.BRN_TAKEN !== 1'b1) begin bad++; $display("FAIL blt got=%b exp=1", bus.BRN_TAKEN); end
        bus.Imm = enc_b(13'h1FF8, 3'b110);
        #1;
        total++; if (bus.BRN_TAKEN !== 1'b0) begin bad++; $display("FAIL bltu got=%b exp=0", bus.BRN_TAKEN); end
        bus.D1 = 32'd9; bus.D2 = 32'd9; bus.Imm = enc_b(13'h1FF8, 3'b010);
        #1;
        total++; if (bus.BRN_TAKEN !== 1'b0 || bus.FLUSH !== 1'b0) begin
            bad++; $display("FAIL f3_010 got=%b%b exp=00", bus.BRN_TAKEN, bus.FLUSH);
        end
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        bus.MEM_REG = 1; bus.DE_WE = 1; bus.Imm = 25'd5; bus.RS1_D = 5'd1; bus.RS2_D = 5'd5;
        #1;
        total++; if (bus.STALL !== 1'b1) begin bad++; $display("FAIL stall_rs2 got=%b exp=1", bus.STALL); end
        bus.Imm = 25'd0; bus.RS2_D = 5'd0;
        #1;
        total++; if (bus.STALL !== 1'b0) begin bad++; $display("FAIL stall_x0 got=%b exp=0", bus.STALL); end
        bus.Imm = 25'd5; bus.RS1_D = 5'd6; bus.RS2_D = 5'd6;
        #1;
        total++; if (bus.STALL !== 1'b0) begin bad++; $display("FAIL stall_nomatch got=%b exp=0", bus.STALL); end
        bus.RS1_D = 5'd5; bus.MEM_REG = 0;
        #1;
        total++; if (bus.STALL !== 1'b0) begin bad++; $display("FAIL stall_noload got=%b exp=0", bus.STALL); end
        tick();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        bus.D1 = 32'h55;
        tick();
        total++; if (bus.ALU_OUT_M !== 32'h55) begin bad++; $display("FAIL pre_async got=%h exp=00000055", bus.ALU_OUT_M); end
        #2 rst = 1'b0;
        #1;
        total++; if (bus.ALU_OUT_M !== 32'd0) begin bad++; $display("FAIL async_clear got=%h exp=0", bus.ALU_OUT_M); end
        #1 rst = 1'b1;
        tick();
        total++; if (bus.ALU_OUT_M !== 32'h55) begin bad++; $display("FAIL post_async got=%h exp=00000055", bus.ALU_OUT_M); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, op2, e_alu, e_tgt;
        logic        e_taken, e_stall;
        logic [4:0]  rd;
        logic [2:0]  e_ctrl;
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            #1;
            a = m_fwd(bus.RS1_EX, bus.D1);
            b = m_fwd(bus.RS2_EX, bus.D2);
            op2 = (bus.ALU_SRC2 == 2'b00) ? b : m_imm(bus.ALU_SRC2, bus.Imm);
            e_alu = m_alu(bus.ALU_CONTROL, a, op2);
            rd = bus.Imm[4:0];
            e_taken = bus.BRN_COND && m_taken(bus.Imm[7:5], a, b);
            e_tgt = bus.PC_EX + m_bimm(bus.Imm);
            e_stall = bus.MEM_REG && bus.DE_WE && rd != 0 && (rd == bus.RS1_D || rd == bus.RS2_D);
            e_ctrl = {bus.MEM_WE, bus.DE_WE, bus.MEM_REG};
            total++; if (bus.BRN_TAKEN !== e_taken || bus.FLUSH !== e_taken) begin
                bad++; $display("FAIL rnd_taken[%0d] got=%b%b exp=%b", i, bus.BRN_TAKEN, bus.FLUSH, e_taken);
            end
            total++; if (bus.BRN_TARGET !== e_tgt) begin bad++; $display("FAIL rnd_target[%0d] got=%h exp=%h", i, bus.BRN_TARGET, e_tgt); end
            total++; if (bus.STALL !== e_stall) begin bad++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", i, bus.STALL, e_stall); end
            tick();
            total++; if (bus.ALU_OUT_M !== e_alu) begin bad++; $display("FAIL rnd_alu[%0d] got=%h exp=%h", i, bus.ALU_OUT_M, e_alu); end
            total++; if (bus.WDATA_M !== b) begin bad++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", i, bus.WDATA_M, b); end
            total++; if (bus.RD_M !== rd) begin bad++; $display("FAIL rnd_rd[%0d] got=%h exp=%h", i, bus.RD_M, rd); end
            total++; if ({bus.MEM_WE_M, bus.DE_WE_M, bus.MEM_REG_M} !== e_ctrl) begin
                bad++; $display("FAIL rnd_ctrl[%0d] got=%b exp=%b", i, {bus.MEM_WE_M, bus.DE_WE_M, bus.MEM_REG_M}, e_ctrl);
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forwarding();
        test_immediates();
        test_branches();
        test_load_use();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
